// File: rtl/kn_ctrl_pkg.sv
// Shared types, constants and the rotated block-mask helper for the KN stream controller.
package kn_ctrl_pkg;

   localparam int DIM_W = 21;
   // Wide enough for G*N*(M/NUM_PES) with every dimension at full width.
   localparam int L_W   = 3 * DIM_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CFG   = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   // Bit j set iff (j - rd_ptr) mod nblk < cnt; nblk must be a power of 2 and <= 32.
   function automatic logic [31:0] rot_mask(input int unsigned rd_ptr,
                                            input int unsigned cnt,
                                            input int unsigned nblk);
      logic [31:0] m;
      m = '0;
      for (int unsigned j = 0; j < 32; j++) begin
         if ((j < nblk) && (((j + nblk - rd_ptr) & (nblk - 1)) < cnt))
            m[j] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/kn_job_cfg.sv
// Derives K_PAD, group count, tail width and total load count from a latched job, plus validity.
module kn_job_cfg
   import kn_ctrl_pkg::*;
#(
   parameter int NUM_PES          = 16,
   parameter int LOG2_PES         = 4,
   parameter int PARA_BLOCKS      = 4,
   parameter int LOG2_PARA_BLOCKS = 2
) (
   input  logic [DIM_W-1:0]          i_m_dim,
   input  logic [DIM_W-1:0]          i_k_dim,
   input  logic [DIM_W-1:0]          i_n_dim,
   output logic [DIM_W-1:0]          o_k_pad,
   output logic [DIM_W-1:0]          o_groups,
   output logic [LOG2_PARA_BLOCKS:0] o_tail,
   output logic [L_W-1:0]            o_loads,
   output logic                      o_valid
);

   localparam int LOG2_W = LOG2_PES + LOG2_PARA_BLOCKS;
   localparam logic [DIM_W:0] W_M1 = (DIM_W + 1)'((PARA_BLOCKS * NUM_PES) - 1);

   logic [DIM_W:0]              k_ext;
   logic [DIM_W:0]              kpad_ext;
   logic [DIM_W:0]              pad_elems;
   logic [LOG2_PARA_BLOCKS-1:0] pad_cnt;

   always_comb begin
      k_ext     = {1'b0, i_k_dim};
      // Round up to a multiple of W with an add and a mask; one spare bit absorbs the carry.
      kpad_ext  = (k_ext + W_M1) & ~W_M1;
      pad_elems = kpad_ext - k_ext;
      pad_cnt   = LOG2_PARA_BLOCKS'(pad_elems >> LOG2_PES);
      o_k_pad   = kpad_ext[DIM_W-1:0];
      o_groups  = DIM_W'(kpad_ext >> LOG2_W);
      o_tail    = (LOG2_PARA_BLOCKS + 1)'(PARA_BLOCKS) - {1'b0, pad_cnt};
      o_loads   = L_W'(o_groups) * L_W'(i_n_dim) * L_W'(i_m_dim >> LOG2_PES);
      o_valid   = (i_m_dim != '0) && (i_k_dim != '0) && (i_n_dim != '0) &&
                  (i_m_dim[LOG2_PES-1:0] == '0) && (i_k_dim[LOG2_PES-1:0] == '0);
   end

endmodule

// File: rtl/kn_stream_ctrl.sv
// Job sequencer for the KN loader, its per-block FIFOs and the PE array: issues loads and pops
// the FIFOs in the loader's rotated, padding-aware order.
module kn_stream_ctrl
   import kn_ctrl_pkg::*;
#(
   parameter int DATA_TYPE        = 8,
   parameter int NUM_PES          = 16,
   parameter int LOG2_PES         = 4,
   parameter int PARA_BLOCKS      = 4,
   parameter int LOG2_PARA_BLOCKS = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_start,
   input  logic [DIM_W-1:0]            i_M_DIM,
   input  logic [DIM_W-1:0]            i_K_DIM,
   input  logic [DIM_W-1:0]            i_N_DIM,
   output logic [DIM_W-1:0]            o_M_DIM,
   output logic [DIM_W-1:0]            o_K_DIM,
   output logic [DIM_W-1:0]            o_K_PAD,
   output logic [DIM_W-1:0]            o_N_DIM,
   output logic                        o_load_clr,
   output logic                        o_load_ena,
   input  logic                        i_load_full,
   input  logic [PARA_BLOCKS-1:0]      i_fifo_empty,
   output logic [PARA_BLOCKS-1:0]      o_fifo_rd_en,
   input  logic                        i_pe_ready,
   output logic                        o_pe_valid,
   output logic [PARA_BLOCKS-1:0]      o_blk_mask,
   output logic [LOG2_PARA_BLOCKS-1:0] o_blk_rot,
   output logic                        o_last_group,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_err
);

   // Parameter sanity guard; intentionally empty when the parameters are consistent.
   if ((DATA_TYPE < 1) || ((1 << LOG2_PES) != NUM_PES) ||
       ((1 << LOG2_PARA_BLOCKS) != PARA_BLOCKS)) begin : g_bad_params
   end

   state_e                      state_q, state_d;
   logic [DIM_W-1:0]            m_q, m_d, k_q, k_d, n_q, n_d, kpad_q, kpad_d;
   logic [DIM_W-1:0]            g_q, g_d, grp_q, grp_d, col_q, col_d, iter_q, iter_d;
   logic [LOG2_PARA_BLOCKS:0]   tail_q, tail_d;
   logic [L_W-1:0]              l_q, l_d, issued_q, issued_d, popped_q, popped_d;
   logic [LOG2_PARA_BLOCKS-1:0] rd_ptr_q, rd_ptr_d, blk_rot_q, blk_rot_d;
   logic [PARA_BLOCKS-1:0]      blk_mask_q, blk_mask_d;
   logic                        err_q, err_d, done_q, done_d;
   logic                        pe_valid_q, pe_valid_d, last_q, last_d;

   logic [DIM_W-1:0]            kpad_c, g_c;
   logic [LOG2_PARA_BLOCKS:0]   tail_c;
   logic [L_W-1:0]              l_c;
   logic                        cfg_ok;

   logic                        last_grp, pop;
   logic [LOG2_PARA_BLOCKS:0]   cnt;
   logic [PARA_BLOCKS-1:0]      mask;

   kn_job_cfg #(
      .NUM_PES          (NUM_PES),
      .LOG2_PES         (LOG2_PES),
      .PARA_BLOCKS      (PARA_BLOCKS),
      .LOG2_PARA_BLOCKS (LOG2_PARA_BLOCKS)
   ) u_job_cfg (
      .i_m_dim  (m_q),
      .i_k_dim  (k_q),
      .i_n_dim  (n_q),
      .o_k_pad  (kpad_c),
      .o_groups (g_c),
      .o_tail   (tail_c),
      .o_loads  (l_c),
      .o_valid  (cfg_ok)
   );

   always_comb begin
      state_d    = state_q;
      m_d        = m_q;
      k_d        = k_q;
      n_d        = n_q;
      kpad_d     = kpad_q;
      g_d        = g_q;
      tail_d     = tail_q;
      l_d        = l_q;
      grp_d      = grp_q;
      col_d      = col_q;
      iter_d     = iter_q;
      issued_d   = issued_q;
      popped_d   = popped_q;
      rd_ptr_d   = rd_ptr_q;
      err_d      = err_q;
      done_d     = 1'b0;
      pe_valid_d = 1'b0;
      blk_mask_d = '0;
      blk_rot_d  = '0;
      last_d     = 1'b0;

      last_grp     = (grp_q == g_q - DIM_W'(1));
      cnt          = last_grp ? tail_q : (LOG2_PARA_BLOCKS + 1)'(PARA_BLOCKS);
      mask         = PARA_BLOCKS'(rot_mask(32'(rd_ptr_q), 32'(cnt), PARA_BLOCKS));
      o_load_ena   = (state_q == ST_RUN) && (issued_q < l_q);
      o_load_clr   = (state_q == ST_CFG) && cfg_ok;
      // A group pops only when every FIFO it touches has data; never a partial group.
      pop          = (state_q == ST_RUN) && i_pe_ready && ((mask & i_fifo_empty) == '0) &&
                     (popped_q < l_q);
      o_fifo_rd_en = pop ? mask : '0;

      if (o_load_ena && !i_load_full)
         issued_d = issued_q + L_W'(1);

      if (pop) begin
         pe_valid_d = 1'b1;
         blk_mask_d = mask;
         blk_rot_d  = rd_ptr_q;
         last_d     = last_grp;
         popped_d   = popped_q + L_W'(1);
         if (last_grp) begin
            grp_d    = '0;
            rd_ptr_d = rd_ptr_q + tail_q[LOG2_PARA_BLOCKS-1:0];
            if (col_q == n_q - DIM_W'(1)) begin
               col_d  = '0;
               iter_d = iter_q + DIM_W'(1);
            end else begin
               col_d  = col_q + DIM_W'(1);
            end
         end else begin
            grp_d = grp_q + DIM_W'(1);
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               m_d     = i_M_DIM;
               k_d     = i_K_DIM;
               n_d     = i_N_DIM;
               err_d   = 1'b0;
               state_d = ST_CFG;
            end
         end
         ST_CFG: begin
            kpad_d = kpad_c;
            if (!cfg_ok) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               g_d      = g_c;
               tail_d   = tail_c;
               l_d      = l_c;
               rd_ptr_d = '0;
               grp_d    = '0;
               col_d    = '0;
               iter_d   = '0;
               issued_d = '0;
               popped_d = '0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (pop && (popped_d == l_q))
               state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // The last group's o_pe_valid is on the bus this cycle; done follows it.
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         m_q        <= '0;
         k_q        <= '0;
         n_q        <= '0;
         kpad_q     <= '0;
         g_q        <= '0;
         tail_q     <= '0;
         l_q        <= '0;
         grp_q      <= '0;
         col_q      <= '0;
         iter_q     <= '0;
         issued_q   <= '0;
         popped_q   <= '0;
         rd_ptr_q   <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         pe_valid_q <= 1'b0;
         blk_mask_q <= '0;
         blk_rot_q  <= '0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         m_q        <= m_d;
         k_q        <= k_d;
         n_q        <= n_d;
         kpad_q     <= kpad_d;
         g_q        <= g_d;
         tail_q     <= tail_d;
         l_q        <= l_d;
         grp_q      <= grp_d;
         col_q      <= col_d;
         iter_q     <= iter_d;
         issued_q   <= issued_d;
         popped_q   <= popped_d;
         rd_ptr_q   <= rd_ptr_d;
         err_q      <= err_d;
         done_q     <= done_d;
         pe_valid_q <= pe_valid_d;
         blk_mask_q <= blk_mask_d;
         blk_rot_q  <= blk_rot_d;
         last_q     <= last_d;
      end
   end

   assign o_M_DIM      = m_q;
   assign o_K_DIM      = k_q;
   assign o_N_DIM      = n_q;
   assign o_K_PAD      = kpad_q;
   assign o_pe_valid   = pe_valid_q;
   assign o_blk_mask   = blk_mask_q;
   assign o_blk_rot    = blk_rot_q;
   assign o_last_group = last_q;
   assign o_busy       = (state_q != ST_IDLE);
   assign o_done       = done_q;
   assign o_err        = err_q;

endmodule

// File: tb/tb_kn_stream_ctrl.sv
// Directed bench for kn_stream_ctrl: scoreboard of expected PE groups built from an
// independent arithmetic model, compared whenever the DUT presents a group.
module tb_kn_stream_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [20:0] i_M_DIM, i_K_DIM, i_N_DIM;
   logic [20:0] o_M_DIM, o_K_DIM, o_K_PAD, o_N_DIM;
   logic        o_load_clr, o_load_ena, i_load_full;
   logic [3:0]  i_fifo_empty, o_fifo_rd_en;
   logic        i_pe_ready, o_pe_valid;
   logic [3:0]  o_blk_mask;
   logic [1:0]  o_blk_rot;
   logic        o_last_group, o_busy, o_done, o_err;

   typedef struct packed {
      logic [3:0] mask;
      logic [1:0] rot;
      logic       last;
   } grp_t;

   grp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   load_cnt = 0;
   int   clr_cnt = 0;
   int   last_valid_cyc = 0;
   int   done_cyc = 0;

   kn_stream_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (i_start),
      .i_M_DIM      (i_M_DIM),
      .i_K_DIM      (i_K_DIM),
      .i_N_DIM      (i_N_DIM),
      .o_M_DIM      (o_M_DIM),
      .o_K_DIM      (o_K_DIM),
      .o_K_PAD      (o_K_PAD),
      .o_N_DIM      (o_N_DIM),
      .o_load_clr   (o_load_clr),
      .o_load_ena   (o_load_ena),
      .i_load_full  (i_load_full),
      .i_fifo_empty (i_fifo_empty),
      .o_fifo_rd_en (o_fifo_rd_en),
      .i_pe_ready   (i_pe_ready),
      .o_pe_valid   (o_pe_valid),
      .o_blk_mask   (o_blk_mask),
      .o_blk_rot    (o_blk_rot),
      .o_last_group (o_last_group),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_err        (o_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      if (o_load_ena && !i_load_full) load_cnt++;
      if (o_load_clr) clr_cnt++;
   end

   always @(negedge clk) begin
      grp_t e;
      if (o_pe_valid) begin
         last_valid_cyc = cyc;
         check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pe_group{mask,rot,last}", 64'({o_blk_mask, o_blk_rot, o_last_group}), 64'(e));
         end
      end
      if (o_done) done_cyc = cyc;
   end

   // Independent model: W=64, NUM_PES=16, PARA_BLOCKS=4, arithmetic with real division.
   task automatic push_model(input int m, input int k, input int n, output int l, output int kp);
      int g, tail, rd, gi, cnt;
      grp_t e;
      kp   = ((k + 63) / 64) * 64;
      g    = kp / 64;
      tail = 4 - (kp - k) / 16;
      l    = g * n * (m / 16);
      rd   = 0;
      for (int i = 0; i < l; i++) begin
         gi     = i % g;
         cnt    = (gi == g - 1) ? tail : 4;
         e.mask = '0;
         for (int b = 0; b < cnt; b++) e.mask[(rd + b) % 4] = 1'b1;
         e.rot  = 2'(rd);
         e.last = (gi == g - 1);
         exp_q.push_back(e);
         if (gi == g - 1) rd = (rd + tail) % 4;
      end
   endtask

   // Returns at the negedge of the CFG cycle.
   task automatic start_job(input int m, input int k, input int n, output int l, output int kp);
      push_model(m, k, n, l, kp);
      load_cnt = 0;
      clr_cnt = 0;
      done_cyc = 0;
      last_valid_cyc = 0;
      i_M_DIM = 21'(m);
      i_K_DIM = 21'(k);
      i_N_DIM = 21'(n);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      check("cfg_busy", 64'(o_busy), 64'd1);
      check("cfg_load_clr", 64'(o_load_clr), 64'd1);
      check("cfg_err_cleared", 64'(o_err), 64'd0);
      check("cfg_m_dim", 64'(o_M_DIM), 64'(m));
   endtask

   task automatic finish_job(input int l, input int kp);
      for (int i = 0; i < 3000 && !o_done; i++) @(negedge clk);
      check("done_seen", 64'(o_done), 64'd1);
      @(negedge clk);
      check("done_gap", 64'(done_cyc - last_valid_cyc), 64'd1);
      check("load_issues", 64'(load_cnt), 64'(l));
      check("load_clr_pulses", 64'(clr_cnt), 64'd1);
      check("sb_drained", 64'(exp_q.size()), 64'd0);
      check("k_pad", 64'(o_K_PAD), 64'(kp));
      check("idle_not_busy", 64'(o_busy), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dims"}, 64'({o_M_DIM, o_K_DIM, o_N_DIM}), 64'd0);
      check({tag, "_kpad"}, 64'(o_K_PAD), 64'd0);
      check({tag, "_load"}, 64'({o_load_clr, o_load_ena}), 64'd0);
      check({tag, "_rd_en"}, 64'(o_fifo_rd_en), 64'd0);
      check({tag, "_pe"}, 64'({o_pe_valid, o_blk_mask, o_blk_rot, o_last_group}), 64'd0);
      check({tag, "_status"}, 64'({o_busy, o_done, o_err}), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int l, kp;
      rst = 1'b1;
      i_start = 1'b0;
      i_M_DIM = '0;
      i_K_DIM = '0;
      i_N_DIM = '0;
      i_load_full = 1'b0;
      i_fifo_empty = '0;
      i_pe_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Single full group per column.
      start_job(16, 64, 2, l, kp);
      finish_job(l, kp);

      // One padded group per column; rotation walks 0,3,2.
      start_job(16, 48, 3, l, kp);
      finish_job(l, kp);

      // Three groups per column, tail of 2; second iteration starts at rot 2.
      start_job(32, 160, 1, l, kp);
      finish_job(l, kp);

      // PE backpressure, load-full hold, then a missing FIFO 2.
      start_job(16, 64, 8, l, kp);
      i_pe_ready = 1'b0;
      i_load_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_ready_low_rd_en", 64'(o_fifo_rd_en), 64'd0);
         check("full_load_ena_held", 64'(o_load_ena), 64'd1);
      end
      check("full_holds_issue", 64'(load_cnt), 64'd0);
      i_load_full = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("bp_ready_low_rd_en", 64'(o_fifo_rd_en), 64'd0);
      end
      check("issue_after_full", 64'(load_cnt), 64'd2);
      i_fifo_empty = 4'b0100;
      i_pe_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("fifo2_empty_no_pop", 64'(o_fifo_rd_en), 64'd0);
      end
      i_fifo_empty = 4'b0000;
      #1;
      check("fifo2_refilled_pop", 64'(o_fifo_rd_en), 64'hF);
      finish_job(l, kp);

      // Invalid K: error, no clear, back to idle quickly.
      load_cnt = 0;
      clr_cnt = 0;
      i_M_DIM = 21'd16;
      i_K_DIM = 21'd40;
      i_N_DIM = 21'd1;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      check("err_cfg_no_clr", 64'(o_load_clr), 64'd0);
      check("err_cfg_busy", 64'(o_busy), 64'd1);
      @(negedge clk);
      check("err_idle_busy", 64'(o_busy), 64'd0);
      check("err_flag", 64'(o_err), 64'd1);
      check("err_clr_count", 64'(clr_cnt), 64'd0);
      repeat (2) @(negedge clk);
      check("err_sticky", 64'(o_err), 64'd1);
      start_job(16, 64, 1, l, kp);
      finish_job(l, kp);

      // Reset in the middle of RUN, then a clean job.
      i_pe_ready = 1'b0;
      start_job(16, 64, 16, l, kp);
      repeat (2) @(negedge clk);
      check("mid_run_load_ena", 64'(o_load_ena), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("mid_rst");
      rst = 1'b0;
      exp_q.delete();
      i_pe_ready = 1'b1;
      @(negedge clk);
      start_job(32, 160, 1, l, kp);
      finish_job(l, kp);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
